// File: rtl/pld_fuse_loader.sv
// Fuse bitstream loader: assembles beats into a shadow, verifies XOR checksum, commits atomically.
// Optional PLD_FUSE_LOCK_EN: one-time-programmable behaviour, configuration locked after first commit.
module pld_fuse_loader #(
    parameter int NUM_PORTS_IN  = 1,
    parameter int NUM_PORTS_OUT = 1,
    parameter int DATA_W        = 8,
    localparam int AND_W     = (2 ** (NUM_PORTS_IN + 2)) * (NUM_PORTS_IN ** 2),
    localparam int OR_W      = NUM_PORTS_OUT * (2 ** (2 * NUM_PORTS_IN)),
    localparam int TOTAL_W   = AND_W + OR_W,
    localparam int NUM_BEATS = (TOTAL_W + DATA_W - 1) / DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic [AND_W-1:0]  and_matrix_fuses_conf_o,
    output logic [OR_W-1:0]   or_matrix_fuses_conf_o,
    output logic              cfg_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int SH_W  = NUM_BEATS * DATA_W;
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]         r_state;
    logic [SH_W-1:0]    r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_acc;
    logic [AND_W-1:0]   r_and;
    logic [OR_W-1:0]    r_or;
    logic               r_cfg_valid;
    logic               r_done;
    logic               r_error;

    // Beats shift in from the top, so beat 0 lands at the LSBs once loading completes.
    logic [SH_W+DATA_W-1:0] w_shift;
    logic                   w_active;

    assign w_shift  = {data_i, r_shadow};
    assign w_active = (r_state == LOAD) || (r_state == CHECK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_and       <= '0;
            r_or        <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_shadow <= '0;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    if (start_i) begin
`ifdef PLD_FUSE_LOCK_EN
                        if (r_cfg_valid) begin
                            r_error <= 1'b1;
                        end else begin
                            r_error <= 1'b0;
                            r_state <= LOAD;
                        end
`else
                        r_error <= 1'b0;
                        r_state <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else if (data_valid_i) begin
                        r_shadow <= w_shift[SH_W+DATA_W-1:DATA_W];
                        r_acc    <= r_acc ^ data_i;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else if (data_valid_i) begin
                        r_state <= IDLE;
                        if (data_i == r_acc) begin
                            r_and       <= r_shadow[AND_W-1:0];
                            r_or        <= r_shadow[TOTAL_W-1:AND_W];
                            r_cfg_valid <= 1'b1;
                            r_done      <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_ready_o            = w_active;
    assign busy_o                  = w_active;
    assign and_matrix_fuses_conf_o = r_and;
    assign or_matrix_fuses_conf_o  = r_or;
    assign cfg_valid_o             = r_cfg_valid;
    assign done_o                  = r_done;
    assign error_o                 = r_error;

endmodule

// File: tb/tb_pld_fuse_loader.sv
// Directed self-checking bench for pld_fuse_loader (N=1, M=1, DATA_W=8).
// Honours PLD_FUSE_LOCK_EN for the reprogramming scenario.
module tb_pld_fuse_loader;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       data_ready_o;
    logic [7:0] and_matrix_fuses_conf_o;
    logic [3:0] or_matrix_fuses_conf_o;
    logic       cfg_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    int n_checks = 0;
    int n_errs   = 0;

    pld_fuse_loader #(
        .NUM_PORTS_IN (1),
        .NUM_PORTS_OUT(1),
        .DATA_W       (8)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .start_i                (start_i),
        .abort_i                (abort_i),
        .data_i                 (data_i),
        .data_valid_i           (data_valid_i),
        .data_ready_o           (data_ready_o),
        .and_matrix_fuses_conf_o(and_matrix_fuses_conf_o),
        .or_matrix_fuses_conf_o (or_matrix_fuses_conf_o),
        .cfg_valid_o            (cfg_valid_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .error_o                (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        data_i       = d;
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_and", 32'(and_matrix_fuses_conf_o), 32'h0);
        chk("rst_or", 32'(or_matrix_fuses_conf_o), 32'h0);
        chk("rst_cfg", 32'(cfg_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(data_ready_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_err", 32'(error_o), 32'h0);

        // gap-free good session
        do_start();
        chk("s1_busy", 32'(busy_o), 32'h1);
        chk("s1_ready", 32'(data_ready_o), 32'h1);
        beat(8'hA5);
        chk("s1_hold_and", 32'(and_matrix_fuses_conf_o), 32'h0);
        beat(8'hF3);
        chk("s1_check_busy", 32'(busy_o), 32'h1);
        chk("s1_pre_done", 32'(done_o), 32'h0);
        beat(8'h56);
        chk("s1_and", 32'(and_matrix_fuses_conf_o), 32'hA5);
        chk("s1_or", 32'(or_matrix_fuses_conf_o), 32'h3);
        chk("s1_cfg", 32'(cfg_valid_o), 32'h1);
        chk("s1_done", 32'(done_o), 32'h1);
        chk("s1_err", 32'(error_o), 32'h0);
        chk("s1_idle", 32'(busy_o), 32'h0);
        tick();
        chk("s1_done_pulse", 32'(done_o), 32'h0);

`ifdef PLD_FUSE_LOCK_EN
        do_start();
        chk("lk_err", 32'(error_o), 32'h1);
        chk("lk_busy", 32'(busy_o), 32'h0);
        chk("lk_and", 32'(and_matrix_fuses_conf_o), 32'hA5);
        chk("lk_or", 32'(or_matrix_fuses_conf_o), 32'h3);
`else
        // abort mid-session, abort beats a simultaneous beat
        do_start();
        beat(8'h11);
        abort_i      = 1'b1;
        data_valid_i = 1'b1;
        data_i       = 8'h99;
        tick();
        abort_i      = 1'b0;
        data_valid_i = 1'b0;
        chk("ab_busy", 32'(busy_o), 32'h0);
        chk("ab_err", 32'(error_o), 32'h0);
        chk("ab_and", 32'(and_matrix_fuses_conf_o), 32'hA5);
        do_start();
        beat(8'h11);
        beat(8'h02);
        beat(8'h13);
        chk("s2_and", 32'(and_matrix_fuses_conf_o), 32'h11);
        chk("s2_or", 32'(or_matrix_fuses_conf_o), 32'h2);
        chk("s2_done", 32'(done_o), 32'h1);
        chk("s2_err", 32'(error_o), 32'h0);
`endif

        // bad checksum after reset
        do_reset();
        do_start();
        beat(8'hA5);
        beat(8'hF3);
        beat(8'h00);
        chk("bad_err", 32'(error_o), 32'h1);
        chk("bad_done", 32'(done_o), 32'h0);
        chk("bad_and", 32'(and_matrix_fuses_conf_o), 32'h0);
        chk("bad_or", 32'(or_matrix_fuses_conf_o), 32'h0);
        chk("bad_cfg", 32'(cfg_valid_o), 32'h0);
        tick();
        chk("bad_sticky", 32'(error_o), 32'h1);

        // session with valid gaps
        do_start();
        chk("gap_err_clr", 32'(error_o), 32'h0);
        beat(8'hA5);
        tick();
        chk("gap_busy1", 32'(busy_o), 32'h1);
        tick();
        chk("gap_busy2", 32'(busy_o), 32'h1);
        beat(8'hF3);
        tick();
        tick();
        tick();
        chk("gap_busy3", 32'(busy_o), 32'h1);
        beat(8'h56);
        chk("gap_and", 32'(and_matrix_fuses_conf_o), 32'hA5);
        chk("gap_or", 32'(or_matrix_fuses_conf_o), 32'h3);
        chk("gap_done", 32'(done_o), 32'h1);
        chk("gap_cfg", 32'(cfg_valid_o), 32'h1);

        // reset mid-session after a commit
        tick();
`ifndef PLD_FUSE_LOCK_EN
        do_start();
        beat(8'h5A);
`endif
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mr_and", 32'(and_matrix_fuses_conf_o), 32'h0);
        chk("mr_or", 32'(or_matrix_fuses_conf_o), 32'h0);
        chk("mr_cfg", 32'(cfg_valid_o), 32'h0);
        chk("mr_busy", 32'(busy_o), 32'h0);
        beat(8'h0F);
        chk("mr_ready", 32'(data_ready_o), 32'h0);
        chk("mr_idle", 32'(busy_o), 32'h0);
        chk("mr_and2", 32'(and_matrix_fuses_conf_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
